display_scan_controller: RTL and testbench

Sequences the 4-digit multiplexed seven-segment display. A prescaler generates per-digit show/blank intervals, and a 2-bit digit select walks 0..3 and drives active-low anodes. A guard blank is inserted between digits to prevent ghosting. A 16-bit display value, loaded from the square-root result path, is double-buffered so updates apply only at frame boundaries; the block feeds the current nibble and blank flag to the downstream seven-segment decoder.

---
 rtl/display_scan_controller.sv | 157 +++++++++++++++
 tb/tb_display_scan_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Scan sequencer for a 4-digit multiplexed seven-segment display: blank/show
// timing per digit, active-low anodes, and a frame-synchronised double-buffered value.
module display_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 500,
  parameter bit LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [1:0]  s,
  output logic [3:0]  an,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic        blank,
  output logic        pending,
  output logic        frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [1:0]       r_s, w_s_n;
  logic [15:0]      r_shadow, w_shadow_n, r_active, w_active_n;
  logic [3:0]       r_shadow_dp, w_shadow_dp_n, r_active_dp, w_active_dp_n;
  logic             r_pending, w_pending_n;
  logic [3:0]       r_an, w_an_n, r_nibble, w_nibble_n;
  logic             r_dp, w_dp_n, r_blank, w_blank_n, r_frame_done;
  logic             w_boundary, w_commit, w_lit;

  // A digit above 0 goes dark when it and every more significant nibble are zero.
  function automatic logic digit_suppressed(input logic [1:0] d, input logic [15:0] v);
    if (!LZ_SUPPRESS) return 1'b0;
    case (d)
      2'd1:    return (v[15:4] == 12'h000);
      2'd2:    return (v[15:8] == 8'h00);
      2'd3:    return (v[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_s_n         = r_s;
    w_shadow_n    = r_shadow;
    w_shadow_dp_n = r_shadow_dp;
    w_active_n    = r_active;
    w_active_dp_n = r_active_dp;
    w_pending_n   = r_pending;
    w_boundary    = 1'b0;
    w_commit      = 1'b0;

    if (!enable) begin
      w_state_n = ST_BLANK;
      w_cnt_n   = '0;
      w_s_n     = 2'd0;
      w_commit  = 1'b1;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_cnt_n   = '0;
            w_state_n = ST_SHOW;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (r_cnt == SHOW_LAST) begin
            w_cnt_n    = '0;
            w_s_n      = r_s + 2'd1;
            w_state_n  = ST_BLANK;
            w_boundary = (r_s == 2'd3);
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      endcase
      w_commit = w_boundary;
    end

    // At a commit point a fresh load bypasses the shadow; otherwise it waits there.
    if (w_commit) begin
      if (load) begin
        w_active_n    = value_in;
        w_active_dp_n = dp_in;
        w_pending_n   = 1'b0;
      end else if (r_pending) begin
        w_active_n    = r_shadow;
        w_active_dp_n = r_shadow_dp;
        w_pending_n   = 1'b0;
      end
    end else if (load) begin
      w_shadow_n    = value_in;
      w_shadow_dp_n = dp_in;
      w_pending_n   = 1'b1;
    end

    // Outputs are derived from next-cycle state so they line up with it.
    w_lit      = (w_state_n == ST_SHOW) && !digit_suppressed(w_s_n, w_active_n);
    w_an_n     = w_lit ? ~(4'b0001 << w_s_n) : 4'b1111;
    w_blank_n  = !w_lit;
    w_dp_n     = w_lit ? ~w_active_dp_n[w_s_n] : 1'b1;
    w_nibble_n = w_active_n[{w_s_n, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_s          <= 2'd0;
      r_shadow     <= 16'h0000;
      r_shadow_dp  <= 4'h0;
      r_active     <= 16'h0000;
      r_active_dp  <= 4'h0;
      r_pending    <= 1'b0;
      r_an         <= 4'b1111;
      r_nibble     <= 4'h0;
      r_dp         <= 1'b1;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_s          <= w_s_n;
      r_shadow     <= w_shadow_n;
      r_shadow_dp  <= w_shadow_dp_n;
      r_active     <= w_active_n;
      r_active_dp  <= w_active_dp_n;
      r_pending    <= w_pending_n;
      r_an         <= w_an_n;
      r_nibble     <= w_nibble_n;
      r_dp         <= w_dp_n;
      r_blank      <= w_blank_n;
      r_frame_done <= w_boundary;
    end
  end

  assign s          = r_s;
  assign an         = r_an;
  assign nibble     = r_nibble;
  assign dp         = r_dp;
  assign blank      = r_blank;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (leading-zero suppression on
// and off) compared every cycle against a frame-position reference model.
module tb_display_scan_controller;

  localparam int RD = 4;
  localparam int BC = 2;
  localparam int SLOT = RD + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset, enable, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;

  logic [1:0] a_s, b_s;
  logic [3:0] a_an, b_an, a_nibble, b_nibble;
  logic       a_dp, b_dp, a_blank, b_blank, a_pending, b_pending, a_fd, b_fd;

  display_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b1)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .s(a_s), .an(a_an), .nibble(a_nibble), .dp(a_dp), .blank(a_blank),
    .pending(a_pending), .frame_done(a_fd));

  display_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b0)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .s(b_s), .an(b_an), .nibble(b_nibble), .dp(b_dp), .blank(b_blank),
    .pending(b_pending), .frame_done(b_fd));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: k counts enabled edges since scanning (re)started.
  int          k = 0;
  logic [15:0] m_act = 16'h0, m_sh = 16'h0;
  logic [3:0]  m_adp = 4'h0, m_sdp = 4'h0;
  bit          m_pend = 1'b0, m_fd = 1'b0;

  task automatic tick();
    bit bnd;
    @(posedge clk);
    if (reset) begin
      k = 0; m_act = 16'h0; m_sh = 16'h0; m_adp = 4'h0; m_sdp = 4'h0;
      m_pend = 1'b0; m_fd = 1'b0;
    end else if (!enable) begin
      k = 0; m_fd = 1'b0;
      if (load) begin m_act = value_in; m_adp = dp_in; m_pend = 1'b0; end
      else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; m_pend = 1'b0; end
    end else begin
      k = k + 1;
      bnd = (k % FRAME) == 0;
      m_fd = bnd;
      if (bnd) begin
        if (load) begin m_act = value_in; m_adp = dp_in; m_pend = 1'b0; end
        else if (m_pend) begin m_act = m_sh; m_adp = m_sdp; m_pend = 1'b0; end
      end else if (load) begin
        m_sh = value_in; m_sdp = dp_in; m_pend = 1'b1;
      end
    end
    #1;
  endtask

  function automatic bit m_show();
    return ((k % FRAME) % SLOT) >= BC;
  endfunction

  function automatic int m_dig();
    return (k % FRAME) / SLOT;
  endfunction

  function automatic logic [13:0] expv(input bit lz);
    int d;
    bit sup, lit;
    logic [3:0] an_e, nib_e;
    logic dp_e;
    d = m_dig();
    sup = lz && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
    lit = m_show() && !sup;
    an_e = lit ? ~(4'b0001 << d) : 4'b1111;
    dp_e = lit ? ~m_adp[d] : 1'b1;
    nib_e = m_show() ? m_act[4*d +: 4] : 4'h0;
    return {2'(d), an_e, dp_e, !lit, m_pend, m_fd, nib_e};
  endfunction

  function automatic logic [13:0] obs_a();
    return {a_s, a_an, a_dp, a_blank, a_pending, a_fd, m_show() ? a_nibble : 4'h0};
  endfunction

  function automatic logic [13:0] obs_b();
    return {b_s, b_an, b_dp, b_blank, b_pending, b_fd, m_show() ? b_nibble : 4'h0};
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
    tick(); tick();
    n_cmp++;
    if ({a_s, a_an, a_nibble, a_dp, a_blank, a_pending, a_fd} !== {2'd0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state got s=%0d an=%b nib=%h dp=%b blank=%b pend=%b fd=%b, want 0 1111 0 1 1 0 0",
               a_s, a_an, a_nibble, a_dp, a_blank, a_pending, a_fd);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan_basic();
    int pulses = 0;
    enable = 1'b0; value_in = 16'h1234; dp_in = 4'h0; load = 1'b1;
    tick(); load = 1'b0;
    n_cmp++;
    if (a_pending !== 1'b0) begin n_bad++; $display("FAIL disabled_load_pending got %b want 0", a_pending); end
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (a_fd === 1'b1) pulses++;
      n_cmp++;
      if (obs_a() !== expv(1'b1)) begin
        n_bad++; $display("FAIL scan_1234 k=%0d got %h want %h", k, obs_a(), expv(1'b1));
      end
    end
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL frame_done_count got %0d want 2", pulses); end
  endtask

  task automatic test_pending();
    enable = 1'b0; value_in = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < SLOT + BC + 1; i++) tick();
    value_in = 16'h0042; load = 1'b1; tick(); load = 1'b0;
    n_cmp++;
    if (a_pending !== 1'b1) begin n_bad++; $display("FAIL pending_set got %b want 1", a_pending); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_cmp++;
      if (obs_a() !== expv(1'b1)) begin
        n_bad++; $display("FAIL pending_frame k=%0d got %h want %h", k, obs_a(), expv(1'b1));
      end
    end
  endtask

  task automatic test_last_wins();
    for (int i = 0; i < 3; i++) tick();
    value_in = 16'h1111; load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    value_in = 16'h2222; load = 1'b1; tick(); load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_cmp++;
      if (obs_a() !== expv(1'b1) || (m_show() && a_nibble === 4'h1)) begin
        n_bad++; $display("FAIL last_wins k=%0d got %h want %h", k, obs_a(), expv(1'b1));
      end
    end
  endtask

  task automatic test_boundary_load();
    for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) tick();
    value_in = 16'h5678; load = 1'b1; tick(); load = 1'b0;
    n_cmp++;
    if (a_pending !== 1'b0 || a_fd !== 1'b1) begin
      n_bad++; $display("FAIL boundary_load pend=%b fd=%b want 0 1", a_pending, a_fd);
    end
    tick(); tick();
    n_cmp++;
    if (a_nibble !== 4'h8 || a_an !== 4'b1110) begin
      n_bad++; $display("FAIL boundary_digit0 nib=%h an=%b want 8 1110", a_nibble, a_an);
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0000, 16'h0100, 16'h0020};
    logic [3:0]  dps  [3] = '{4'b0000, 4'b0100, 4'b1111};
    for (int v = 0; v < 3; v++) begin
      enable = 1'b0; value_in = vals[v]; dp_in = dps[v]; load = 1'b1; tick(); load = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        n_cmp++;
        if (obs_a() !== expv(1'b1)) begin
          n_bad++; $display("FAIL lz_on v=%h k=%0d got %h want %h", vals[v], k, obs_a(), expv(1'b1));
        end
        n_cmp++;
        if (obs_b() !== expv(1'b0)) begin
          n_bad++; $display("FAIL lz_off v=%h k=%0d got %h want %h", vals[v], k, obs_b(), expv(1'b0));
        end
      end
    end
    dp_in = 4'h0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; value_in = 16'h4321; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 2 * SLOT + BC; i++) tick();
    value_in = 16'h9999; load = 1'b1; tick(); load = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++;
    if (a_s !== 2'd0 || a_an !== 4'hF || a_pending !== 1'b0 || a_blank !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid s=%0d an=%b pend=%b blank=%b want 0 1111 0 1", a_s, a_an, a_pending, a_blank);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_cmp++;
      if (obs_a() !== expv(1'b1)) begin
        n_bad++; $display("FAIL after_reset k=%0d got %h want %h", k, obs_a(), expv(1'b1));
      end
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0; value_in = 16'h7777; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < SLOT + BC + 1; i++) tick();
    enable = 1'b0; tick();
    n_cmp++;
    if (a_an !== 4'hF || a_s !== 2'd0 || a_blank !== 1'b1) begin
      n_bad++; $display("FAIL enable_drop an=%b s=%0d blank=%b want 1111 0 1", a_an, a_s, a_blank);
    end
    enable = 1'b1;
    for (int i = 0; i < SLOT + 2; i++) begin
      tick();
      n_cmp++;
      if (obs_a() !== expv(1'b1)) begin
        n_bad++; $display("FAIL reenable k=%0d got %h want %h", k, obs_a(), expv(1'b1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      enable   = ($urandom_range(0, 79) != 0);
      load     = ($urandom_range(0, 9) == 0);
      value_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in    = 4'($urandom);
      tick();
      n_cmp++;
      if (obs_a() !== expv(1'b1)) begin
        n_bad++; $display("FAIL random_lz_on i=%0d got %h want %h", i, obs_a(), expv(1'b1));
      end
      n_cmp++;
      if (obs_b() !== expv(1'b0)) begin
        n_bad++; $display("FAIL random_lz_off i=%0d got %h want %h", i, obs_b(), expv(1'b0));
      end
    end
    reset = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_pending();
    test_last_wins();
    test_boundary_load();
    test_lz();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
